ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline, directly upstream of the MEM stage.
- Computes ALU results for RV32I ops in a single cycle and RV32M multiply ops in a single cycle.
- Computes RV32M divide/remainder ops with an iterative radix-2 divider (FSM + counter) that stalls the front end.
- Owns the EX/MEM pipeline register, which drives ctrl_mem, rd_mem, pc4_mem, alu_result and write_data1.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_CYCLES, 32, number of BUSY iterations of the divider; must equal XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_ex  input  1  ID/EX holds a real instruction.
- flush  input  1  branch/jump redirect; kills the current EX instruction.
- ctrl_ex  input  5  MEM/WB control bits, passed through to ctrl_mem.
- alu_op  input  5  operation select (encoding below).
- alu_src  input  1  operand B select: 1 = imm_ex, 0 = rs2_data.
- rs1_data  input  32  operand A.
- rs2_data  input  32  rs2 value; also the store data.
- imm_ex  input  32  sign-extended immediate.
- pc_ex  input  32  PC of the instruction.
- rd_ex  input  32  destination register field, zero-extended.
- stall  output  1  holds PC, IF/ID and ID/EX.
- ctrl_mem  output  5  registered.
- rd_mem  output  32  registered.
- pc4_mem  output  32  registered; pc_ex+4.
- alu_result  output  32  registered.
- write_data1  output  32  registered; rs2_data.

Behaviour:
- Reset: all EX/MEM outputs = 0; FSM = IDLE; counter = 0; stall = 0.
- Operand B: B = alu_src ? imm_ex : rs2_data. A = rs1_data.
- alu_op encoding:
  - 0 ADD, 1 SUB
  - 2 SLL, 6 SRL, 7 SRA (shift amount = B[4:0])
  - 3 SLT (signed), 4 SLTU (unsigned); result is 1 or 0
  - 5 XOR, 8 OR, 9 AND
  - 10 LUI (result = B), 11 AUIPC (result = pc_ex + B)
  - 16 MUL (low 32 bits of product)
  - 17 MULH (signed×signed), 18 MULHSU (signed×unsigned), 19 MULHU (unsigned×unsigned); all return the high 32 bits of the 64-bit product
  - 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - All other codes produce result 0.
- Single-cycle ops: when valid_ex=1, flush=0 and the FSM is IDLE, the next edge loads the EX/MEM register with the result, ctrl_ex, rd_ex, pc_ex+4 and rs2_data.
- Bubble: if valid_ex=0, the next edge loads ctrl_mem = 0. Data fields are don't-care; the bench must not check them.
- Divider FSM, states IDLE / BUSY / DONE:
  - IDLE → BUSY: valid, non-flushed op 20–23 with a normal case. Latch the operand magnitudes and sign info, clear the counter, set stall=1 combinationally this cycle, load a bubble into EX/MEM.
  - BUSY: one restoring shift-subtract step per cycle; stall=1; bubble into EX/MEM. When the counter reaches DIV_CYCLES-1, go to DONE.
  - DONE: stall=0. Apply the sign fix-up: quotient is negated if the signs differ (DIV); remainder takes the dividend's sign (REM). The edge at the end of DONE loads the result into EX/MEM with the still-held ID/EX fields, then the FSM returns to IDLE.
  - Latency: stall is high for 33 cycles; the result appears at the MEM input 34 edges after first presentation.
- Divider special cases complete in a single cycle with no stall:
  - Divisor = 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM with the same operands returns 0.
- flush: has priority over everything.
  - The next edge loads a bubble.
  - An IDLE divide is not started.
  - In BUSY or DONE, the FSM returns to IDLE, stall drops to 0 that cycle, and no result is written.
- valid_ex dropping while BUSY is not legal (ID/EX is held). The FSM ignores it.
- reset in BUSY: at the reset edge, FSM = IDLE, stall = 0, outputs = 0.
- Divide followed immediately by a divide: the second starts only from IDLE, i.e. one cycle after DONE, because ID/EX advances at the DONE edge.

Test Plan:
- ADD: rs1=5, imm=0xFFFFFFFD, alu_src=1 → alu_result=2 next edge; pc4_mem=pc_ex+4; stall stays 0.
- Signed divide: DIV -7/2 → stall high exactly 33 cycles; alu_result=0xFFFFFFFD (-3). REM -7/2 → 0xFFFFFFFF (-1). DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF in 1 cycle with no stall. DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL 3 × -4 → 0xFFFFFFF4.
- Flush in BUSY cycle 10 → stall low that cycle; FSM IDLE; only bubbles (ctrl_mem=0) reach MEM.
- Reset asserted in BUSY cycle 5 → all outputs 0 and stall 0 after the edge. Then an ADD 1+1 → 2 on the following edge.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the RV32IM pipeline: single-cycle ALU/multiplier, iterative
// radix-2 divider that stalls the front end, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_ex,
    input  logic            flush,
    input  logic [4:0]      ctrl_ex,
    input  logic [4:0]      alu_op,
    input  logic            alu_src,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] rd_ex,
    output logic            stall,
    output logic [4:0]      ctrl_mem,
    output logic [XLEN-1:0] rd_mem,
    output logic [XLEN-1:0] pc4_mem,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] write_data1
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_LUI    = 5'd10;
    localparam logic [4:0] OP_AUIPC  = 5'd11;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    dvd_q, rem_q, dvs_q;
    logic               neg_quo_q, neg_rem_q, want_rem_q;
    logic [4:0]         ctrl_q;
    logic [XLEN-1:0]    rd_q, pc4_q, res_q, wd_q;

    logic [XLEN-1:0]    op_b, alu_res, ex_res, div_res, a_mag, b_mag;
    logic [4:0]         shamt;
    logic               is_div_op, signed_div, div_zero, div_ovf, div_start, wb_load;
    logic               mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0]  mul_a, mul_b, prod;
    logic [XLEN:0]      rem_shift, trial;
    logic [XLEN-1:0]    rem_step_d, quo_step_d;

    assign op_b  = alu_src ? imm_ex : rs2_data;
    assign shamt = op_b[4:0];

    assign is_div_op  = (alu_op[4:2] == 3'b101);
    assign signed_div = is_div_op && !alu_op[0];
    assign div_zero   = (op_b == '0);
    assign div_ovf    = signed_div && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign div_start  = (state_q == IDLE) && valid_ex && !flush && is_div_op && !div_zero && !div_ovf;

    assign stall   = !flush && (div_start || (state_q == BUSY));
    assign wb_load = !flush && (((state_q == IDLE) && valid_ex && !div_start) || (state_q == DONE));

    // One shared multiplier; sign-extending per op makes the 64-bit product exact mod 2^64.
    assign mul_a_sgn = (alu_op == OP_MULH) || (alu_op == OP_MULHSU);
    assign mul_b_sgn = (alu_op == OP_MULH);
    assign mul_a     = {{XLEN{mul_a_sgn & rs1_data[XLEN-1]}}, rs1_data};
    assign mul_b     = {{XLEN{mul_b_sgn & op_b[XLEN-1]}}, op_b};
    assign prod      = mul_a * mul_b;

    assign a_mag = (signed_div && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    assign b_mag = (signed_div && op_b[XLEN-1])     ? -op_b     : op_b;

    assign rem_shift  = {rem_q, dvd_q[XLEN-1]};
    assign trial      = rem_shift - {1'b0, dvs_q};
    assign rem_step_d = trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_step_d = {dvd_q[XLEN-2:0], ~trial[XLEN]};

    assign div_res = want_rem_q ? (neg_rem_q ? -rem_q : rem_q)
                                : (neg_quo_q ? -dvd_q : dvd_q);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:    alu_res = rs1_data + op_b;
            OP_SUB:    alu_res = rs1_data - op_b;
            OP_SLL:    alu_res = rs1_data << shamt;
            OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
            OP_XOR:    alu_res = rs1_data ^ op_b;
            OP_SRL:    alu_res = rs1_data >> shamt;
            OP_SRA:    alu_res = $signed(rs1_data) >>> shamt;
            OP_OR:     alu_res = rs1_data | op_b;
            OP_AND:    alu_res = rs1_data & op_b;
            OP_LUI:    alu_res = op_b;
            OP_AUIPC:  alu_res = pc_ex + op_b;
            OP_MUL:    alu_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_res = prod[2*XLEN-1:XLEN];
            // Only the special cases reach EX/MEM from here; the overflow quotient equals the dividend.
            OP_DIV, OP_DIVU: alu_res = div_zero ? '1 : rs1_data;
            OP_REM, OP_REMU: alu_res = div_zero ? rs1_data : '0;
            default:   alu_res = '0;
        endcase
    end

    assign ex_res = (state_q == DONE) ? div_res : alu_res;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            want_rem_q <= 1'b0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            pc4_q      <= '0;
            res_q      <= '0;
            wd_q       <= '0;
        end else begin
            ctrl_q <= wb_load ? ctrl_ex : '0;
            if (wb_load) begin
                rd_q  <= rd_ex;
                pc4_q <= pc_ex + 32'd4;
                res_q <= ex_res;
                wd_q  <= rs2_data;
            end
            case (state_q)
                IDLE: begin
                    if (div_start) begin
                        state_q    <= BUSY;
                        cnt_q      <= '0;
                        dvd_q      <= a_mag;
                        rem_q      <= '0;
                        dvs_q      <= b_mag;
                        neg_quo_q  <= signed_div && (rs1_data[XLEN-1] ^ op_b[XLEN-1]);
                        neg_rem_q  <= signed_div && rs1_data[XLEN-1];
                        want_rem_q <= alu_op[1];
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        dvd_q <= quo_step_d;
                        rem_q <= rem_step_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctrl_mem    = ctrl_q;
    assign rd_mem      = rd_q;
    assign pc4_mem     = pc4_q;
    assign alu_result  = res_q;
    assign write_data1 = wd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: randomized and directed instructions checked every cycle
// against an arithmetic reference model plus hand-computed literal results.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset, valid_ex, flush, alu_src, stall;
    logic [4:0]  ctrl_ex, alu_op, ctrl_mem;
    logic [31:0] rs1_data, rs2_data, imm_ex, pc_ex, rd_ex;
    logic [31:0] rd_mem, pc4_mem, alu_result, write_data1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: cycles since a long divide began (0 = none in flight)
    int          phase = 0;
    logic [4:0]  e_ctrl;
    logic [31:0] e_rd, e_pc4, e_res, e_wd;
    bit          e_dv = 1'b0;

    ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .valid_ex(valid_ex), .flush(flush),
        .ctrl_ex(ctrl_ex), .alu_op(alu_op), .alu_src(alu_src),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_ex(imm_ex),
        .pc_ex(pc_ex), .rd_ex(rd_ex), .stall(stall), .ctrl_mem(ctrl_mem),
        .rd_mem(rd_mem), .pc4_mem(pc4_mem), .alu_result(alu_result),
        .write_data1(write_data1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] opnd_b();
        return alu_src ? imm_ex : rs2_data;
    endfunction

    function automatic bit is_long_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 5'd20 || op > 5'd23) return 1'b0;
        if (b == 32'd0) return 1'b0;
        if ((op == 5'd20 || op == 5'd22) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return sa >>> b[4:0];
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd11: return pc + b;
            5'd16: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            5'd17: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            5'd18: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
            5'd19: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            5'd20: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd22: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            5'd23: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit model_stall();
        if (flush) return 1'b0;
        if (phase == 0) return valid_ex && is_long_div(alu_op, rs1_data, opnd_b());
        if (phase <= 32) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            e_ctrl = '0; e_rd = '0; e_pc4 = '0; e_res = '0; e_wd = '0;
            e_dv = 1'b1; phase = 0;
        end else if (flush) begin
            e_ctrl = '0; e_dv = 1'b0; phase = 0;
        end else if ((phase == 0 && valid_ex && !is_long_div(alu_op, rs1_data, opnd_b())) || phase == 33) begin
            e_ctrl = ctrl_ex; e_rd = rd_ex; e_pc4 = pc_ex + 32'd4;
            e_res  = ref_alu(alu_op, rs1_data, opnd_b(), pc_ex);
            e_wd   = rs2_data; e_dv = 1'b1; phase = 0;
        end else begin
            e_ctrl = '0; e_dv = 1'b0;
            if (phase > 0 || valid_ex) phase = phase + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (!reset) check("stall", {31'd0, stall}, {31'd0, model_stall()});
            check("ctrl_mem", {27'd0, ctrl_mem}, {27'd0, e_ctrl});
            if (e_dv) begin
                check("rd_mem", rd_mem, e_rd);
                check("pc4_mem", pc4_mem, e_pc4);
                check("alu_result", alu_result, e_res);
                check("write_data1", write_data1, e_wd);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic src, input logic v);
        valid_ex = v;
        alu_op   = op;
        alu_src  = src;
        rs1_data = a;
        if (src) begin imm_ex = b; rs2_data = $urandom; end
        else     begin rs2_data = b; imm_ex = $urandom; end
        ctrl_ex  = 5'($urandom_range(1, 31));
        rd_ex    = $urandom_range(1, 31);
        pc_ex    = $urandom & 32'hFFFF_FFFC;
    endtask

    // Presents one instruction and holds ID/EX while the model says the stage stalls.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic src, input logic v, input int fl_at, output int stalls);
        int guard;
        bit s;
        set_inputs(op, a, b, src, v);
        stalls = 0;
        guard  = 0;
        forever begin
            flush = (guard == fl_at);
            @(negedge clk);
            if (stall) stalls++;
            s = model_stall();
            @(posedge clk);
            #1;
            guard++;
            if (!s) break;
            if (guard > 40) begin
                check("issue timeout", 32'(guard), 32'd40);
                break;
            end
        end
        flush = 1'b0;
    endtask

    task automatic lit(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic src, input logic [31:0] exp, input int exp_st);
        int st;
        issue(op, a, b, src, 1'b1, -1, st);
        check({name, " result"}, alu_result, exp);
        check({name, " stalls"}, 32'(st), 32'(exp_st));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    logic [4:0] ops [24] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                             5'd10, 5'd11, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21,
                             5'd22, 5'd23, 5'd12, 5'd15, 5'd24, 5'd31};

    initial begin
        int st;
        int fl_at;
        reset = 1'b1; valid_ex = 1'b0; flush = 1'b0; alu_src = 1'b0;
        ctrl_ex = '0; alu_op = '0; rs1_data = '0; rs2_data = '0;
        imm_ex = '0; pc_ex = '0; rd_ex = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("reset ctrl_mem", {27'd0, ctrl_mem}, 32'd0);
        check("reset alu_result", alu_result, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        lit("ADD", 5'd0, 32'd5, 32'hFFFF_FFFD, 1'b1, 32'd2, 0);
        check("ADD pc4", pc4_mem, pc_ex + 32'd4);
        lit("DIV", 5'd20, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 33);
        lit("REM", 5'd22, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 33);
        lit("DIVU", 5'd21, 32'd100, 32'd7, 1'b0, 32'd14, 33);
        lit("REMU", 5'd23, 32'd100, 32'd7, 1'b0, 32'd2, 33);
        lit("DIVU by 0", 5'd21, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 0);
        lit("REM by 0", 5'd22, 32'd5, 32'd0, 1'b0, 32'd5, 0);
        lit("DIV ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 0);
        lit("REM ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 0);
        lit("MULH", 5'd17, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 0);
        lit("MULHU", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 0);
        lit("MUL", 5'd16, 32'd3, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFF4, 0);
        lit("SRA", 5'd7, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000, 0);
        lit("SLT", 5'd3, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd1, 0);
        lit("SLTU", 5'd4, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 0);

        issue(5'd20, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 10, st);
        check("flush stalls", 32'(st), 32'd10);
        check("flush ctrl_mem", {27'd0, ctrl_mem}, 32'd0);
        lit("ADD after flush", 5'd0, 32'd7, 32'd8, 1'b0, 32'd15, 0);

        set_inputs(5'd21, 32'd1000, 32'd3, 1'b0, 1'b1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_inputs(5'd0, 32'd1, 32'd1, 1'b0, 1'b1);
        #1;
        check("rst-busy stall", {31'd0, stall}, 32'd0);
        check("rst-busy ctrl_mem", {27'd0, ctrl_mem}, 32'd0);
        check("rst-busy alu_result", alu_result, 32'd0);
        check("rst-busy pc4_mem", pc4_mem, 32'd0);
        tick();
        check("ADD after reset", alu_result, 32'd2);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 19))
                0:       fl_at = 0;
                1:       fl_at = $urandom_range(1, 33);
                default: fl_at = -1;
            endcase
            issue(ops[$urandom_range(0, 23)], pick(), pick(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) != 0), fl_at, st);
        end
        valid_ex = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
